blackjack_shoe: RTL and testbench
=================================

Name: blackjack_shoe

Overview:
Parametrised multi-deck card shoe for the blackjack controller. It replaces the single-deck shuffler/loader. While the active-low seed button is held, a counter runs, and its value becomes the shuffle seed. The block then fills and Fisher-Yates shuffles NUM_DECKS x 52 cards and serves one card per request until the cut point is reached. The game controller consumes cards through a req/valid pulse interface.

Parameters:
NUM_DECKS, 1, number of 52-card decks in the shoe (1..8); N = 52*NUM_DECKS
CUT_RESERVE, 0, cards left undealt when exhausted asserts (0..N-1)
CNT_W, 9, width of the position and count registers; must satisfy 2^CNT_W > N

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
seed_btn  in  1  active-low button, synchronised internally; hold duration sets the seed
card_req  in  1  one-cycle request for the next card
card_valid  out  1  one-cycle pulse; card fields valid this cycle
card_rank  out  4  1=A .. 13=K
card_suit  out  2  0..3
ready  out  1  shoe shuffled; requests accepted
busy  out  1  fill or shuffle in progress
exhausted  out  1  dealt count reached N-CUT_RESERVE
cards_left  out  CNT_W  N-CUT_RESERVE minus cards dealt; 0 when not ready or exhausted

Behaviour:
- Reset (rst low, async): all outputs 0, state LOAD, seed counter 0, deal pointer 0.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. It advances one step per cycle in FILL and SHUFFLE and on every rejected sample.
- LOAD: waits for the synchronised seed_btn to go low, then moves to SEED.
- SEED: a 16-bit counter increments every cycle while the button is low; it wraps.
  - On release, LFSR = counter. If counter is 0, LFSR = 1 instead.
  - Next state FILL; busy=1.
- FILL: one card per cycle, k = 0..N-1. card[k] = (rank = (k mod 13)+1, suit = (k div 13) mod 4), generated with wrap counters and no dividers. Takes N cycles.
- SHUFFLE: i runs from N-1 down to 1.
  - Candidate j = LFSR & mask, where mask is the smallest all-ones value >= i.
  - If j > i: reject, advance the LFSR, and retry next cycle.
  - Otherwise swap card[i] and card[j] in one cycle, then decrement i.
  - When i reaches 0: busy=0, ready=1, cards_left = N-CUT_RESERVE, pointer = 0, state READY.
- READY:
  - card_req=1 makes card_valid=1 on the next cycle with card[pointer]. The pointer increments and cards_left decrements at that same edge.
  - Requests on consecutive cycles give valids on consecutive cycles.
  - When the dealt count reaches N-CUT_RESERVE: ready=0, exhausted=1, cards_left=0, state EMPTY, at the same edge that presents the final card.
- EMPTY: requests are ignored, with no card_valid. The block stays here until reset, or reshuffle when enabled.
- card_req outside READY is ignored and not queued. seed_btn activity outside LOAD/SEED is ignored.
- card_rank and card_suit hold their last value between valids.

Optional Feature:
Macro RESHUFFLE_EN.
- Defined:
  - Adds input reshuffle (1 bit, one-cycle pulse).
  - In READY or EMPTY, a pulse returns the block to SHUFFLE over the current card array, with no new seed and no FILL. exhausted=0, ready=0, busy=1.
  - If card_req and reshuffle arrive in the same cycle, reshuffle wins and no card is issued.
  - Ignored in other states.
- Undefined: the port does not exist, and only reset leaves EMPTY.

Test Plan:
1. NUM_DECKS=1, hold seed_btn 300 cycles, wait for ready (timeout 64*N), then issue 52 reqs -> 52 valids; each (rank,suit) pair appears exactly once; rank sum = 364; cards_left counts 52->0; exhausted=1 after the 52nd card; a 53rd req gives no valid.
2. Determinism: two runs with a 300-cycle hold -> identical 52-card sequence; a 301-cycle hold -> different sequence.
3. Seed zero: a 65536-cycle hold gives the same sequence as a 1-cycle hold; no lockup, ready asserts.
4. NUM_DECKS=6, CUT_RESERVE=78: 234 reqs issued every cycle -> 234 consecutive valids; each pair appears 6 times within the full 312-card array order; exhausted at card 234.
5. Async reset mid-SHUFFLE and again mid-deal -> all outputs 0 with no clock edge; card_req during busy gives no valid.
6. With RESHUFFLE_EN: deal 10 cards, pulse reshuffle together with card_req -> no valid, busy=1, then ready with cards_left=52; the deck is still a full permutation.

Source files
------------

// File: rtl/blackjack_shoe.sv
// blackjack_shoe
// Multi-deck card shoe for the blackjack controller. While the active-low
// seed button is held, a 16-bit counter runs. Its value on release seeds a
// 16-bit Galois LFSR. The shoe then fills NUM_DECKS x 52 cards in suit/rank
// order, runs a Fisher-Yates shuffle over them, and deals one card per
// request until only CUT_RESERVE cards remain.
//
// Optional build macro: RESHUFFLE_EN adds a reshuffle pulse input. It
// reshuffles the current card array from READY or EMPTY.
//
// Parameters:
//   NUM_DECKS   - decks in the shoe (1..8), N = 52*NUM_DECKS
//   CUT_RESERVE - cards left undealt when the shoe reports exhausted
//   CNT_W       - width of position/count registers, 2^CNT_W > N, CNT_W <= 16
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous reset, active-low
//   seed_btn   in   active-low seed button (asynchronous, synchronised here)
//   card_req   in   one-cycle request for the next card
//   reshuffle  in   one-cycle reshuffle pulse (RESHUFFLE_EN builds only)
//   card_valid out  one-cycle pulse, card_rank/card_suit valid this cycle
//   card_rank  out  1=A .. 13=K, holds between valids
//   card_suit  out  0..3, holds between valids
//   ready      out  shoe shuffled, requests accepted
//   busy       out  fill or shuffle in progress
//   exhausted  out  deal limit reached
//   cards_left out  cards still dealable, 0 when not ready
module blackjack_shoe #(
    parameter int NUM_DECKS   = 1,
    parameter int CUT_RESERVE = 0,
    parameter int CNT_W       = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_btn,
    input  logic             card_req,
`ifdef RESHUFFLE_EN
    input  logic             reshuffle,
`endif
    output logic             card_valid,
    output logic [3:0]       card_rank,
    output logic [1:0]       card_suit,
    output logic             ready,
    output logic             busy,
    output logic             exhausted,
    output logic [CNT_W-1:0] cards_left
);

    localparam int N     = 52 * NUM_DECKS;
    localparam int LIMIT = N - CUT_RESERVE;
    localparam int IDX_W = $clog2(N);

    localparam logic [CNT_W-1:0] N_LAST    = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] DEAL_CNT  = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] DEAL_LAST = CNT_W'(LIMIT - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    localparam logic [2:0] S_LOAD  = 3'd0;
    localparam logic [2:0] S_SEED  = 3'd1;
    localparam logic [2:0] S_FILL  = 3'd2;
    localparam logic [2:0] S_SHUF  = 3'd3;
    localparam logic [2:0] S_READY = 3'd4;
    localparam logic [2:0] S_EMPTY = 3'd5;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
    function automatic logic [15:0] f_lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Smear the highest set bit downwards: smallest all-ones value >= v.
    function automatic logic [CNT_W-1:0] f_mask(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] m;
        m = v;
        for (int s = 1; s < CNT_W; s = s * 2) begin
            m = m | (m >> s);
        end
        return m;
    endfunction

    logic [1:0]       r_sync;
    logic [2:0]       r_state;
    logic [15:0]      r_seed_cnt;
    logic [15:0]      r_lfsr;
    logic [CNT_W-1:0] r_idx;       // fill position k, then shuffle index i
    logic [3:0]       r_rank_ctr;
    logic [1:0]       r_suit_ctr;
    logic [CNT_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_left;
    logic             r_valid;
    logic [3:0]       r_rank;
    logic [1:0]       r_suit;
    logic             r_ready;
    logic             r_busy;
    logic             r_exh;
    logic [5:0]       r_cards [N]; // {rank, suit}

    logic             w_btn_low;
    logic             w_resh;
    logic [CNT_W-1:0] w_j;
    logic             w_reject;
    logic [5:0]       w_card_at_ptr;

    assign w_btn_low     = ~r_sync[1];
    assign w_j           = r_lfsr[CNT_W-1:0] & f_mask(r_idx);
    assign w_reject      = (w_j > r_idx);
    assign w_card_at_ptr = r_cards[r_ptr[IDX_W-1:0]];

`ifdef RESHUFFLE_EN
    assign w_resh = reshuffle;
`else
    assign w_resh = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // The synchroniser idles at the released level so reset
            // cannot look like a button press.
            r_sync     <= 2'b11;
            r_state    <= S_LOAD;
            r_seed_cnt <= '0;
            r_lfsr     <= 16'd1;
            r_idx      <= '0;
            r_rank_ctr <= 4'd1;
            r_suit_ctr <= '0;
            r_ptr      <= '0;
            r_left     <= '0;
            r_valid    <= 1'b0;
            r_rank     <= '0;
            r_suit     <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_exh      <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], seed_btn};
            r_valid <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    // The detecting cycle counts too, so the seed equals the
                    // number of cycles the button was seen low (mod 2^16).
                    if (w_btn_low) begin
                        r_seed_cnt <= r_seed_cnt + 16'd1;
                        r_state    <= S_SEED;
                    end
                end
                S_SEED: begin
                    if (w_btn_low) begin
                        r_seed_cnt <= r_seed_cnt + 16'd1;
                    end else begin
                        // A zero seed would lock the LFSR at zero.
                        r_lfsr     <= (r_seed_cnt == 16'd0) ? 16'd1 : r_seed_cnt;
                        r_state    <= S_FILL;
                        r_busy     <= 1'b1;
                        r_idx      <= '0;
                        r_rank_ctr <= 4'd1;
                        r_suit_ctr <= '0;
                    end
                end
                S_FILL: begin
                    r_lfsr <= f_lfsr_step(r_lfsr);
                    if (r_rank_ctr == 4'd13) begin
                        r_rank_ctr <= 4'd1;
                        r_suit_ctr <= r_suit_ctr + 2'd1;
                    end else begin
                        r_rank_ctr <= r_rank_ctr + 4'd1;
                    end
                    // The last fill position is also the first shuffle index.
                    if (r_idx == N_LAST) begin
                        r_state <= S_SHUF;
                    end else begin
                        r_idx <= r_idx + ONE;
                    end
                end
                S_SHUF: begin
                    r_lfsr <= f_lfsr_step(r_lfsr);
                    if (!w_reject) begin
                        if (r_idx == ONE) begin
                            r_state <= S_READY;
                            r_busy  <= 1'b0;
                            r_ready <= 1'b1;
                            r_left  <= DEAL_CNT;
                            r_ptr   <= '0;
                        end else begin
                            r_idx <= r_idx - ONE;
                        end
                    end
                end
                S_READY: begin
                    if (w_resh) begin
                        r_state <= S_SHUF;
                        r_idx   <= N_LAST;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_exh   <= 1'b0;
                        r_left  <= '0;
                    end else if (card_req) begin
                        r_valid <= 1'b1;
                        r_rank  <= w_card_at_ptr[5:2];
                        r_suit  <= w_card_at_ptr[1:0];
                        r_ptr   <= r_ptr + ONE;
                        if (r_ptr == DEAL_LAST) begin
                            r_state <= S_EMPTY;
                            r_ready <= 1'b0;
                            r_exh   <= 1'b1;
                            r_left  <= '0;
                        end else begin
                            r_left <= r_left - ONE;
                        end
                    end
                end
                S_EMPTY: begin
                    if (w_resh) begin
                        r_state <= S_SHUF;
                        r_idx   <= N_LAST;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_exh   <= 1'b0;
                        r_left  <= '0;
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

    // Card storage: written in FILL, swapped in place during SHUFFLE.
    always_ff @(posedge clk) begin
        if (r_state == S_FILL) begin
            r_cards[r_idx[IDX_W-1:0]] <= {r_rank_ctr, r_suit_ctr};
        end else if (r_state == S_SHUF && !w_reject) begin
            r_cards[r_idx[IDX_W-1:0]] <= r_cards[w_j[IDX_W-1:0]];
            r_cards[w_j[IDX_W-1:0]]   <= r_cards[r_idx[IDX_W-1:0]];
        end
    end

    assign card_valid = r_valid;
    assign card_rank  = r_rank;
    assign card_suit  = r_suit;
    assign ready      = r_ready;
    assign busy       = r_busy;
    assign exhausted  = r_exh;
    assign cards_left = r_left;

endmodule

// File: tb/tb_blackjack_shoe.sv
// Testbench for blackjack_shoe: a single-deck shoe (A) and a six-deck shoe
// with a 78-card cut (B). Requests push expected responses into per-shoe
// queues, and a monitor per shoe pops and compares on every card_valid.
module tb_blackjack_shoe;

    typedef struct {
        int         due;
        bit         chk;
        logic [5:0] card;
        int         left;
        bit         exh;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Shoe A: 1 deck, no reserve
    logic       a_rst = 1'b0, a_btn = 1'b1, a_req = 1'b0;
    logic       a_valid, a_ready, a_busy, a_exh;
    logic [3:0] a_rank;
    logic [1:0] a_suit;
    logic [8:0] a_left;
    // Shoe B: 6 decks, 78 reserved
    logic       b_rst = 1'b0, b_btn = 1'b1, b_req = 1'b0;
    logic       b_valid, b_ready, b_busy, b_exh;
    logic [3:0] b_rank;
    logic [1:0] b_suit;
    logic [8:0] b_left;
`ifdef RESHUFFLE_EN
    logic       a_resh = 1'b0, b_resh = 1'b0;
`endif

    blackjack_shoe #(.NUM_DECKS(1), .CUT_RESERVE(0), .CNT_W(9)) u_a (
        .clk(clk), .rst(a_rst), .seed_btn(a_btn), .card_req(a_req),
`ifdef RESHUFFLE_EN
        .reshuffle(a_resh),
`endif
        .card_valid(a_valid), .card_rank(a_rank), .card_suit(a_suit),
        .ready(a_ready), .busy(a_busy), .exhausted(a_exh), .cards_left(a_left)
    );

    blackjack_shoe #(.NUM_DECKS(6), .CUT_RESERVE(78), .CNT_W(9)) u_b (
        .clk(clk), .rst(b_rst), .seed_btn(b_btn), .card_req(b_req),
`ifdef RESHUFFLE_EN
        .reshuffle(b_resh),
`endif
        .card_valid(b_valid), .card_rank(b_rank), .card_suit(b_suit),
        .ready(b_ready), .busy(b_busy), .exhausted(b_exh), .cards_left(b_left)
    );

    exp_t       qa[$], qb[$];
    logic [5:0] cap_a[$], cap_b[$];
    logic [5:0] m52[$], m312[$];
    logic [5:0] seq1[$], seq2[$], seq3[$], seq4[$], seq5[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Reference shoe: ordered fill, N LFSR steps during fill, then
    // Fisher-Yates with rejection sampling, one LFSR step per draw.
    function automatic void build_model(input int n, input logic [15:0] seed,
                                        output logic [5:0] deck[$]);
        logic [15:0] l;
        logic [5:0]  t;
        int          m, j;
        deck = {};
        for (int k = 0; k < n; k++) deck.push_back({4'((k % 13) + 1), 2'((k / 13) % 4)});
        l = seed;
        for (int k = 0; k < n; k++) l = lstep(l);
        for (int i = n - 1; i >= 1; i--) begin
            m = 1;
            while (m < i) m = m * 2 + 1;
            j = int'(l) & m;
            l = lstep(l);
            while (j > i) begin
                j = int'(l) & m;
                l = lstep(l);
            end
            t = deck[i]; deck[i] = deck[j]; deck[j] = t;
        end
    endfunction

    function automatic int seq_diff(input logic [5:0] x[$], input logic [5:0] y[$]);
        int d = 0;
        if (x.size() != y.size()) return 9999;
        foreach (x[k]) if (x[k] !== y[k]) d++;
        return d;
    endfunction

    // exact=1: every (rank,suit) exactly 'copies' times; else at most 'copies'.
    task automatic perm_check(input logic [5:0] q[$], input int copies, input bit exact,
                              input int exp_len, input string nm);
        int cnt [16][4];
        int bad = 0;
        foreach (cnt[r, s]) cnt[r][s] = 0;
        foreach (q[k]) cnt[q[k][5:2]][q[k][1:0]]++;
        foreach (cnt[r, s]) begin
            if (r >= 1 && r <= 13) begin
                if (exact ? (cnt[r][s] != copies) : (cnt[r][s] > copies)) bad++;
            end else if (cnt[r][s] != 0) bad++;
        end
        chk({nm, "_len"}, q.size(), exp_len);
        chk({nm, "_pairs"}, bad, 0);
    endtask

    // Monitors
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (a_valid) begin
            cap_a.push_back({a_rank, a_suit});
            if (qa.size() == 0) chk("a_unexpected_valid", 1, 0);
            else begin
                e = qa.pop_front();
                chk("a_valid_cycle", cyc, e.due);
                if (e.chk) chk("a_card", {a_rank, a_suit}, e.card);
                chk("a_cards_left", a_left, e.left);
                chk("a_exhausted", a_exh, e.exh);
            end
        end else if (qa.size() > 0 && qa[0].due <= cyc) begin
            chk("a_missing_valid", 0, 1);
            void'(qa.pop_front());
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (b_valid) begin
            cap_b.push_back({b_rank, b_suit});
            if (qb.size() == 0) chk("b_unexpected_valid", 1, 0);
            else begin
                e = qb.pop_front();
                chk("b_valid_cycle", cyc, e.due);
                if (e.chk) chk("b_card", {b_rank, b_suit}, e.card);
                chk("b_cards_left", b_left, e.left);
                chk("b_exhausted", b_exh, e.exh);
            end
        end else if (qb.size() > 0 && qb[0].due <= cyc) begin
            chk("b_missing_valid", 0, 1);
            void'(qb.pop_front());
        end
    end

    task automatic reset_a();
        a_rst = 1'b0; a_btn = 1'b1; a_req = 1'b0;
        qa.delete();
        repeat (2) @(posedge clk);
        #1 a_rst = 1'b1;
    endtask

    task automatic seed_a(input int hold);
        @(posedge clk);
        #1 a_btn = 1'b0;
        repeat (hold) @(posedge clk);
        #1 a_btn = 1'b1;
    endtask

    task automatic wait_ready_a(input string nm);
        int t = 0;
        while (!a_ready && t < 64 * 52) begin
            @(negedge clk);
            t++;
        end
        chk(nm, a_ready, 1);
    endtask

    task automatic deal_a(input int cnt, input bit c, input logic [5:0] mq[$],
                          input int start, input int base);
        for (int k = 0; k < cnt; k++) begin
            @(posedge clk);
            #1 a_req = 1'b1;
            qa.push_back('{cyc + 1, c, (c ? mq[start + k] : 6'd0), base - k - 1, (base - k - 1) == 0});
        end
        @(posedge clk);
        #1 a_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic zero_a(input string nm);
        chk({nm, "_valid"}, a_valid, 0);
        chk({nm, "_rank"}, a_rank, 0);
        chk({nm, "_suit"}, a_suit, 0);
        chk({nm, "_ready"}, a_ready, 0);
        chk({nm, "_busy"}, a_busy, 0);
        chk({nm, "_exh"}, a_exh, 0);
        chk({nm, "_left"}, a_left, 0);
    endtask

    // Full single-deck run from reset with a given hold; returns dealt order.
    task automatic full_run_a(input int hold, input bit c, output logic [5:0] sq[$]);
        reset_a();
        seed_a(hold);
        wait_ready_a("a_ready_timeout");
        chk("a_left_at_ready", a_left, 52);
        cap_a.delete();
        deal_a(52, c, m52, 0, 52);
        sq = cap_a;
    endtask

    initial begin
        build_model(52, 16'd1, m52);
        build_model(312, 16'd1, m312);

        // Reset state
        reset_a();
        b_rst = 1'b0;
        @(negedge clk);
        zero_a("reset");
        chk("reset_b_ready", b_ready, 0);
        chk("reset_b_left", b_left, 0);

        // Single deck, 300-cycle hold: full deal and properties
        full_run_a(300, 1'b0, seq1);
        chk("deal52_exhausted", a_exh, 1);
        chk("deal52_ready", a_ready, 0);
        chk("deal52_left", a_left, 0);
        perm_check(seq1, 1, 1'b1, 52, "deal52");
        begin
            int rs = 0;
            foreach (seq1[k]) rs += int'(seq1[k][5:2]);
            chk("rank_sum", rs, 364);
        end
        @(posedge clk);
        #1 a_req = 1'b1;
        @(posedge clk);
        #1 a_req = 1'b0;
        @(negedge clk);
        chk("req53_no_valid", a_valid, 0);

        // Determinism
        full_run_a(300, 1'b0, seq2);
        chk("seed300_repeat_diff", seq_diff(seq1, seq2), 0);
        full_run_a(301, 1'b0, seq3);
        chk("seed301_differs", seq_diff(seq1, seq3) != 0, 1);

        // Seed 1 against the reference model, then a wrapped (zero) seed
        full_run_a(1, 1'b1, seq4);
        full_run_a(65536, 1'b0, seq5);
        chk("seed0_matches_seed1", seq_diff(seq4, seq5), 0);

        // Async reset mid-shuffle, with a request while busy
        reset_a();
        seed_a(5);
        begin
            int t = 0;
            while (!a_busy && t < 100) begin @(negedge clk); t++; end
        end
        repeat (60) @(negedge clk);
        chk("shuf_busy", a_busy, 1);
        chk("shuf_left", a_left, 0);
        @(posedge clk);
        #1 a_req = 1'b1;
        @(posedge clk);
        #1 a_req = 1'b0;
        @(negedge clk);
        chk("busy_req_no_valid", a_valid, 0);
        #2 a_rst = 1'b0;
        #1 zero_a("rst_shuf");

        // Async reset mid-deal
        reset_a();
        seed_a(1);
        wait_ready_a("a_ready_timeout2");
        deal_a(5, 1'b1, m52, 0, 52);
        @(posedge clk);
        #1 a_req = 1'b1;
        @(posedge clk);
        #1 a_req = 1'b0;
        chk("predeal_valid", a_valid, 1);
        chk("predeal_ready", a_ready, 1);
        qa.delete();
        #1 a_rst = 1'b0;
        #1 zero_a("rst_deal");

        // Six decks, 78-card cut, back-to-back requests
        b_rst = 1'b0; b_btn = 1'b1; b_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 b_rst = 1'b1;
        @(posedge clk);
        #1 b_btn = 1'b0;
        @(posedge clk);
        #1 b_btn = 1'b1;
        begin
            int t = 0;
            while (!b_ready && t < 64 * 312) begin @(negedge clk); t++; end
        end
        chk("b_ready_timeout", b_ready, 1);
        chk("b_left_at_ready", b_left, 234);
        cap_b.delete();
        for (int k = 0; k < 234; k++) begin
            @(posedge clk);
            #1 b_req = 1'b1;
            qb.push_back('{cyc + 1, 1'b1, m312[k], 233 - k, k == 233});
        end
        @(posedge clk);
        #1 b_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("b_exhausted_end", b_exh, 1);
        chk("b_ready_end", b_ready, 0);
        perm_check(cap_b, 6, 1'b0, 234, "deal234");

`ifdef RESHUFFLE_EN
        // Reshuffle wins over a simultaneous request
        reset_a();
        seed_a(1);
        wait_ready_a("a_ready_timeout3");
        deal_a(10, 1'b1, m52, 0, 52);
        @(posedge clk);
        #1 begin a_req = 1'b1; a_resh = 1'b1; end
        @(posedge clk);
        #1 begin a_req = 1'b0; a_resh = 1'b0; end
        @(negedge clk);
        chk("resh_no_valid", a_valid, 0);
        chk("resh_busy", a_busy, 1);
        chk("resh_ready", a_ready, 0);
        wait_ready_a("resh_ready_timeout");
        chk("resh_left", a_left, 52);
        cap_a.delete();
        deal_a(52, 1'b0, m52, 0, 52);
        perm_check(cap_a, 1, 1'b1, 52, "resh_deal");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
